// File: rtl/led_cal_ctrl.sv
// LED calibration and multiplexing controller: per-channel DC binary search, then PGA gain
// search, then time-multiplexed RUN mode that emits one tagged ADC sample per channel slot.
module led_cal_ctrl #(
  parameter int N_CH    = 2,
  parameter int ADC_W   = 8,
  parameter int DC_W    = 7,
  parameter int PGA_W   = 4,
  parameter int WIN     = 1000,
  parameter int SETTLE  = 16,
  parameter int TGT_LO  = 120,
  parameter int TGT_HI  = 135,
  parameter int CLIP_LO = 10,
  parameter int CLIP_HI = 245,
  parameter int SLOT    = 10,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [ADC_W-1:0] ADC,
  input  logic             Find_setting,
  output logic [N_CH-1:0]  LED_EN,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic             CLK_Filter,
  output logic [ADC_W-1:0] adc_value,
  output logic [CH_W-1:0]  adc_ch,
  output logic             adc_valid,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  fail
);

  localparam int CNT_W  = $clog2(SETTLE + WIN + 1) + 1;
  localparam int SCNT_W = $clog2(SLOT) + 1;
  localparam int B_W    = $clog2(DC_W) + 1;
  localparam logic [CNT_W-1:0]  C_SET   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  C_END   = CNT_W'(SETTLE + WIN);
  localparam logic [SCNT_W-1:0] S_LAST  = SCNT_W'(SLOT - 1);
  localparam logic [B_W-1:0]    B_TOP   = B_W'(DC_W - 1);
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);
  localparam logic [ADC_W-1:0]  T_LO    = ADC_W'(TGT_LO);
  localparam logic [ADC_W-1:0]  T_HI    = ADC_W'(TGT_HI);
  localparam logic [ADC_W-1:0]  K_LO    = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0]  K_HI    = ADC_W'(CLIP_HI);

  typedef enum logic [2:0] {IDLE, DC_SEARCH, PGA_SEARCH, NEXT_CH, RUN} state_t;

  state_t            r_state, w_state_n;
  logic [CH_W-1:0]   r_ch, r_slot, w_slot_n;
  logic [B_W-1:0]    r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic [SCNT_W-1:0] r_scnt;
  logic [ADC_W-1:0]  r_vmin, r_vmax, r_adc_value, w_avg;
  logic [DC_W-1:0]   r_dc, w_bit, w_dc_dec, w_dc_lock_val;
  logic [PGA_W-1:0]  r_pga, w_pga_val;
  logic [N_CH-1:0]   r_led, r_fail;
  logic [CH_W-1:0]   r_adc_ch;
  logic              r_arm, r_clkf, r_adc_valid, r_busy, r_done;
  logic              w_win_end, w_sample, w_hi, w_lo, w_inband, w_clip, w_b_zero, w_pga_max;
  logic              w_dc_lock, w_pga_store;
  logic [DC_W-1:0]   r_dc_mem  [N_CH];
  logic [PGA_W-1:0]  r_pga_mem [N_CH];

  function automatic logic [ADC_W-1:0] midpoint(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return ADC_W'(s >> 1);
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] k);
    for (int i = 0; i < N_CH; i++) onehot[i] = (k == CH_W'(i));
  endfunction

  assign w_win_end     = (r_cnt == C_END);
  assign w_sample      = (r_cnt >= C_SET) && (r_cnt < C_END);
  assign w_avg         = midpoint(r_vmax, r_vmin);
  assign w_hi          = (w_avg > T_HI);
  assign w_lo          = (w_avg < T_LO);
  assign w_inband      = !w_hi && !w_lo;
  assign w_clip        = (r_vmin < K_LO) || (r_vmax > K_HI);
  assign w_bit         = DC_W'(1) << r_b;
  assign w_dc_dec      = w_hi ? r_dc : (r_dc & ~w_bit);
  assign w_dc_lock_val = w_inband ? r_dc : w_dc_dec;
  assign w_b_zero      = (r_b == '0);
  assign w_pga_max     = &r_pga;
  assign w_pga_val     = w_clip ? ((r_pga == '0) ? '0 : r_pga - 1'b1) : r_pga;
  assign w_dc_lock     = (r_state == DC_SEARCH) && !r_arm && w_win_end && (w_inband || w_b_zero);
  assign w_pga_store   = (r_state == PGA_SEARCH) && w_win_end && (w_clip || w_pga_max);
  assign w_slot_n      = (r_slot == CH_LAST) ? '0 : r_slot + 1'b1;

  always_ff @(posedge CLK) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (Find_setting) begin
      w_state_n = DC_SEARCH;
    end else begin
      case (r_state)
        DC_SEARCH:  if (w_dc_lock) w_state_n = PGA_SEARCH;
        PGA_SEARCH: if (w_pga_store) w_state_n = NEXT_CH;
        NEXT_CH:    w_state_n = (r_ch == CH_LAST) ? RUN : DC_SEARCH;
        default:    w_state_n = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_clkf <= 1'b0;  r_adc_valid <= 1'b0;  r_adc_value <= '0;  r_adc_ch <= '0;
      r_led  <= '0;    r_dc  <= '0;    r_pga  <= '0;    r_busy <= 1'b0;  r_done <= 1'b0;
      r_fail <= '0;    r_ch  <= '0;    r_b    <= '0;    r_cnt  <= '0;    r_arm  <= 1'b0;
      r_slot <= '0;    r_scnt <= '0;   r_vmin <= '1;    r_vmax <= '0;
    end else begin
      r_clkf      <= ~r_clkf;
      r_adc_valid <= 1'b0;
      if (Find_setting) begin
        r_ch  <= '0;  r_led  <= onehot('0);  r_dc   <= '0;    r_pga <= '0;
        r_busy <= 1'b1;  r_done <= 1'b0;  r_fail <= '0;
        r_b   <= B_TOP;  r_arm  <= 1'b1;  r_cnt  <= '0;
      end else begin
        case (r_state)
          DC_SEARCH, PGA_SEARCH: begin
            // The first trial bit is applied one cycle after entry; its window starts there.
            if (r_arm) begin
              r_dc <= r_dc | w_bit;  r_arm <= 1'b0;  r_cnt <= '0;
              r_vmin <= '1;  r_vmax <= '0;
            end else if (w_win_end) begin
              r_cnt <= '0;  r_vmin <= '1;  r_vmax <= '0;
              if (r_state == DC_SEARCH) begin
                if (!w_inband) begin
                  if (w_b_zero) begin
                    r_dc <= w_dc_dec;
                    r_fail[r_ch] <= 1'b1;
                  end else begin
                    r_dc <= w_dc_dec | (w_bit >> 1);
                    r_b  <= r_b - 1'b1;
                  end
                end
              end else if (w_clip) begin
                r_pga <= w_pga_val;
                if (r_pga == '0) r_fail[r_ch] <= 1'b1;
              end else if (!w_pga_max) begin
                r_pga <= r_pga + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (w_sample) begin
                if (ADC < r_vmin) r_vmin <= ADC;
                if (ADC > r_vmax) r_vmax <= ADC;
              end
            end
          end
          NEXT_CH: begin
            if (r_ch == CH_LAST) begin
              r_busy <= 1'b0;  r_done <= 1'b1;  r_slot <= '0;  r_scnt <= '0;
              r_led  <= onehot('0);  r_dc <= r_dc_mem[0];  r_pga <= r_pga_mem[0];
            end else begin
              r_ch  <= r_ch + 1'b1;  r_led <= onehot(r_ch + 1'b1);
              r_dc  <= '0;  r_pga <= '0;  r_b <= B_TOP;  r_arm <= 1'b1;
            end
          end
          RUN: begin
            if (r_scnt == S_LAST) begin
              r_adc_value <= ADC;  r_adc_ch <= r_slot;  r_adc_valid <= 1'b1;
              r_scnt <= '0;  r_slot <= w_slot_n;  r_led <= onehot(w_slot_n);
              r_dc   <= r_dc_mem[w_slot_n];  r_pga <= r_pga_mem[w_slot_n];
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      if (Find_setting) begin
        for (int i = 0; i < N_CH; i++) begin
          r_dc_mem[i]  <= '0;
          r_pga_mem[i] <= '0;
        end
      end else begin
        if (w_dc_lock)   r_dc_mem[r_ch]  <= w_dc_lock_val;
        if (w_pga_store) r_pga_mem[r_ch] <= w_pga_val;
      end
    end
  end

  assign LED_EN     = r_led;
  assign DC_Comp    = r_dc;
  assign PGA_Gain   = r_pga;
  assign CLK_Filter = r_clkf;
  assign adc_value  = r_adc_value;
  assign adc_ch     = r_adc_ch;
  assign adc_valid  = r_adc_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;

endmodule

// File: tb/tb_led_cal_ctrl.sv
// Bench for led_cal_ctrl: an analog plant model drives ADC from the DUT's LED/DC/PGA outputs,
// and expected calibration results come from hand tables and an abstract search model.
module tb_led_cal_ctrl;

  localparam int N_CH = 2, ADC_W = 8, DC_W = 7, PGA_W = 4, WIN = 8, SETTLE = 2, SLOT = 4;

  logic             CLK = 1'b0;
  logic             rst;
  logic [ADC_W-1:0] ADC;
  logic             Find_setting;
  logic [N_CH-1:0]  LED_EN;
  logic [DC_W-1:0]  DC_Comp;
  logic [PGA_W-1:0] PGA_Gain;
  logic             CLK_Filter;
  logic [ADC_W-1:0] adc_value;
  logic             adc_ch;
  logic             adc_valid;
  logic             busy, done;
  logic [N_CH-1:0]  fail;

  led_cal_ctrl #(.N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .PGA_W(PGA_W),
                 .WIN(WIN), .SETTLE(SETTLE), .SLOT(SLOT)) dut (
    .CLK(CLK), .rst(rst), .ADC(ADC), .Find_setting(Find_setting),
    .LED_EN(LED_EN), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain), .CLK_Filter(CLK_Filter),
    .adc_value(adc_value), .adc_ch(adc_ch), .adc_valid(adc_valid),
    .busy(busy), .done(done), .fail(fail));

  always #5 CLK = ~CLK;

  typedef struct {
    int m0, k0, s0, m1, k1, s1;
    int edc0, epga0, ef0, edc1, epga1, ef1;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int pm[2], pk[2], ps[2];
  bit tog = 1'b0;

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Plant: midpoint M - K*DC, square-wave swing of S*(gain+1) on the lit channel.
  task automatic drive();
    int ch, v;
    ch = LED_EN[1] ? 1 : 0;
    v = pm[ch] - pk[ch] * int'(DC_Comp) + (tog ? 1 : -1) * ps[ch] * (int'(PGA_Gain) + 1);
    ADC = 8'(clamp8(v));
    tog = ~tog;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    drive();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_out();
    return int'({LED_EN, DC_Comp, PGA_Gain, CLK_Filter, adc_value, adc_ch, adc_valid, busy, done, fail});
  endfunction

  // Abstract calibration outcome for one channel of the plant above.
  task automatic model(input int m, input int k, input int s, output int dc, output int pga, output int f);
    int code, trial, mid, hi, lo, avg, g;
    bit locked;
    code = 0; locked = 0; f = 0;
    for (int b = DC_W - 1; b >= 0 && !locked; b--) begin
      trial = code | (1 << b);
      mid = m - k * trial;
      hi = clamp8(mid + s); lo = clamp8(mid - s);
      avg = (hi + lo) / 2;
      if (avg >= 120 && avg <= 135) begin code = trial; locked = 1; end
      else if (avg > 135) code = trial;
    end
    if (!locked) f = 1;
    dc = code;
    mid = m - k * code;
    pga = 15;
    for (g = 0; g <= 15; g++) begin
      hi = clamp8(mid + s * (g + 1)); lo = clamp8(mid - s * (g + 1));
      if (lo < 10 || hi > 245) begin
        pga = (g > 0) ? g - 1 : 0;
        if (g == 0) f = 1;
        break;
      end
    end
  endtask

  task automatic run_case(input vec_t v);
    int n, last, ks, edc[2], epga[2];
    pm[0] = v.m0; pk[0] = v.k0; ps[0] = v.s0;
    pm[1] = v.m1; pk[1] = v.k1; ps[1] = v.s1;
    edc[0] = v.edc0; edc[1] = v.edc1; epga[0] = v.epga0; epga[1] = v.epga1;
    Find_setting = 1'b1;
    step();
    Find_setting = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_fail", fail, 0);
    chk("restart_led", LED_EN, 1);
    chk("restart_dc", DC_Comp, 0);
    n = 0;
    while (!done && n < 4000) begin step(); n++; end
    chk("calib_done_timeout", done, 1);
    if (!done) return;
    chk("calib_busy_cleared", busy, 0);
    chk("calib_fail", fail, v.ef1 * 2 + v.ef0);
    last = 0;
    for (int c = 0; c < 4 * SLOT * N_CH; c++) begin
      ks = (c / SLOT) % N_CH;
      chk("run_led", LED_EN, 1 << ks);
      chk("run_dc", DC_Comp, edc[ks]);
      chk("run_pga", PGA_Gain, epga[ks]);
      chk("run_valid", adc_valid, (c % SLOT == 0 && c > 0) ? 1 : 0);
      if (c % SLOT == 0 && c > 0) begin
        chk("run_adc_ch", adc_ch, (ks + N_CH - 1) % N_CH);
        chk("run_adc_value", adc_value, last);
      end
      last = ADC;
      step();
    end
    step();
  endtask

  vec_t tbl[4];
  vec_t rv;

  initial begin
    tbl[0] = '{200, 1, 5, 128, 0, 10,  80, 15, 0,  64, 10, 0};
    tbl[1] = '{250, 0, 0, 128, 0, 0,  127,  0, 1,  64, 15, 0};
    tbl[2] = '{128, 0, 10, 200, 1, 5,  64, 10, 0,  80, 15, 0};
    tbl[3] = '{50, 0, 0, 250, 0, 0,     0, 15, 1, 127,  0, 1};
    pm = '{0, 0}; pk = '{0, 0}; ps = '{0, 0};
    rst = 1'b1; Find_setting = 1'b0; ADC = '0;

    repeat (3) step();
    chk("reset_outputs", all_out(), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("clk_filter_toggle", CLK_Filter, (i % 2 == 0) ? 1 : 0);
      chk("idle_busy", busy, 0);
    end

    for (int i = 0; i < 4; i++) run_case(tbl[i]);

    for (int r = 0; r < 8; r++) begin
      rv.m0 = int'($urandom_range(300, 0)); rv.k0 = int'($urandom_range(1, 0));
      rv.s0 = int'($urandom_range(25, 0));
      rv.m1 = int'($urandom_range(300, 0)); rv.k1 = int'($urandom_range(1, 0));
      rv.s1 = int'($urandom_range(25, 0));
      model(rv.m0, rv.k0, rv.s0, rv.edc0, rv.epga0, rv.ef0);
      model(rv.m1, rv.k1, rv.s1, rv.edc1, rv.epga1, rv.ef1);
      run_case(rv);
    end

    // Find_setting held high keeps restarting; the first trial bit appears once it drops.
    Find_setting = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_find_busy", busy, 1);
      chk("held_find_dc", DC_Comp, 0);
      chk("held_find_led", LED_EN, 1);
    end
    Find_setting = 1'b0;
    step();
    chk("first_trial_dc", DC_Comp, 64);

    // Reset in the middle of calibration.
    repeat (30) step();
    chk("midcal_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("midcal_reset_outputs", all_out(), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_idle_led", LED_EN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
